// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and constants for the SPI register bridge.
package spi_reg_pkg;
    localparam int REG_ADDR_W = 6;
    localparam int HDR_WR_BIT = 7;
    localparam int HDR_AI_BIT = 6;
    localparam int HDR_ADDR_MSB = 5;
    localparam logic [7:0] STATUS_DEFAULT = 8'hA5;
    typedef enum logic [2:0] {HDR, WR, RD_ISSUE, RD_CAP, RD_WAIT} state_t;
endpackage

// File: rtl/spi_ss_sync.sv
// spi_ss_sync: 2-flop chip-select synchronizer, resets to deselected.
module spi_ss_sync (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    output logic ss_s
);
    logic meta;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {ss_s, meta} <= 2'b11;
        else {ss_s, meta} <= {meta, ss};
    end
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI byte stream to 64x8 register bus decoder.
// SPI_REG_BRIDGE_ECHO_EN: echo received write data on spi_din.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] STATUS_BYTE = STATUS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic                  spi_done,
    input  logic [7:0]            spi_dout,
    output logic [7:0]            spi_din,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [7:0]            reg_rdata,
    output logic                  frame_active
);
    state_t state;
    logic ss_s, ss_q, ai, abort;
    spi_ss_sync u_sync (.clk(clk), .rst(rst), .ss(ss), .ss_s(ss_s));
    // a byte completing as ss_s rises is still processed; the abort lands a cycle later
    assign abort = ss_s && !(spi_done && !ss_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HDR;
            ss_q <= 1'b1;
            ai <= 1'b0;
            spi_din <= STATUS_BYTE;
            reg_addr <= '0;
            reg_wdata <= '0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            ss_q <= ss_s;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (reg_we && ai) reg_addr <= reg_addr + 1'b1;
            if (abort) begin
                state <= HDR;
                frame_active <= 1'b0;
                spi_din <= STATUS_BYTE;
            end else begin
                case (state)
                    HDR: if (spi_done) begin
                        ai <= spi_dout[HDR_AI_BIT];
                        reg_addr <= spi_dout[HDR_ADDR_MSB:0];
                        frame_active <= 1'b1;
                        state <= spi_dout[HDR_WR_BIT] ? WR : RD_ISSUE;
                        reg_re <= !spi_dout[HDR_WR_BIT];
                    end
                    WR: if (spi_done) begin
                        reg_wdata <= spi_dout;
                        reg_we <= 1'b1;
`ifdef SPI_REG_BRIDGE_ECHO_EN
                        spi_din <= spi_dout;
`endif
                    end
                    RD_ISSUE: state <= RD_CAP;
                    RD_CAP: begin
                        spi_din <= reg_rdata;
                        if (ai) reg_addr <= reg_addr + 1'b1;
                        state <= RD_WAIT;
                    end
                    RD_WAIT: if (spi_done) begin
                        reg_re <= 1'b1;
                        state <= RD_ISSUE;
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: randomized self-checking bench for spi_reg_bridge.
module tb_spi_reg_bridge;
    typedef logic [7:0] bq_t[$];
    typedef logic [13:0] wq_t[$];
    localparam logic [7:0] ST = 8'hA5;
    logic clk = 0, rst = 0, ss = 1, spi_done = 0, ld = 0;
    logic [7:0] spi_dout = 0, spi_din, reg_wdata, reg_rdata = 0, ld_d = 0, next_miso = 0;
    logic [5:0] reg_addr, ld_a = 0;
    logic reg_we, reg_re, frame_active;
    int tests = 0, fails = 0;
    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    wq_t wlog;
    always #5 clk = ~clk;
    spi_reg_bridge dut (.clk(clk), .rst(rst), .ss(ss), .spi_done(spi_done), .spi_dout(spi_dout),
        .spi_din(spi_din), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata), .frame_active(frame_active));
    // register file on the bus: read data one cycle after reg_re
    always @(posedge clk) begin
        if (ld) mem[ld_a] <= ld_d;
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
    end
    always @(negedge clk) if (reg_we) wlog.push_back({reg_addr, reg_wdata});
    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic poke(input logic [5:0] a, input logic [7:0] d);
        ld_a = a; ld_d = d; ld = 1;
        tick();
        ld = 0;
        ref_mem[a] = d;
    endtask
    task automatic start_frame();
        ss = 0;
        tick(4);
        next_miso = spi_din;
    endtask
    // the SPI engine loads spi_din for the next byte shortly after a byte completes
    task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
        miso = next_miso;
        tick(14);
        spi_dout = b; spi_done = 1;
        tick();
        spi_done = 0;
        tick();
        next_miso = spi_din;
    endtask
    task automatic end_frame();
        tick(2);
        ss = 1;
        tick(4);
    endtask
    task automatic run_frame(input bq_t tx, output bq_t rx);
        logic [7:0] b;
        rx = {};
        start_frame();
        foreach (tx[k]) begin send_byte(tx[k], b); rx.push_back(b); end
        end_frame();
    endtask
    function automatic void model_frame(input bq_t tx, output bq_t rx, output wq_t w);
        logic [5:0] a;
        a = tx[0][5:0];
        rx = {}; w = {};
        for (int k = 0; k < tx.size(); k++) begin
            if (tx[0][7]) begin
`ifdef SPI_REG_BRIDGE_ECHO_EN
                rx.push_back(k >= 2 ? tx[k-1] : ST);
`else
                rx.push_back(ST);
`endif
                if (k > 0) begin
                    w.push_back({a, tx[k]});
                    ref_mem[a] = tx[k];
                    if (tx[0][6]) a = a + 6'd1;
                end
            end else begin
                rx.push_back(k >= 2 ? ref_mem[a + (tx[0][6] ? 6'(k-2) : 6'd0)] : ST);
            end
        end
    endfunction
    task automatic test_reset();
        rst = 0;
        tick(3);
        tests++; if (spi_din !== ST) begin fails++; $display("FAIL reset spi_din got %h exp %h", spi_din, ST); end
        tests++; if (reg_addr !== 6'd0) begin fails++; $display("FAIL reset reg_addr got %h exp 00", reg_addr); end
        tests++; if (reg_wdata !== 8'd0) begin fails++; $display("FAIL reset reg_wdata got %h exp 00", reg_wdata); end
        tests++; if ({reg_we, reg_re, frame_active} !== 3'b000) begin fails++; $display("FAIL reset strobes we/re/fa got %b exp 000", {reg_we, reg_re, frame_active}); end
        rst = 1;
        tick(2);
        for (int i = 0; i < 64; i++) poke(6'(i), 8'($urandom));
    endtask
    task automatic test_write_ai();
        bq_t tx, rx, ex, mexp;
        wq_t we, wexp;
        logic [7:0] b;
        tx = '{8'hC3, 8'h11, 8'h22, 8'h33};
        wexp = '{{6'd3, 8'h11}, {6'd4, 8'h22}, {6'd5, 8'h33}};
`ifdef SPI_REG_BRIDGE_ECHO_EN
        mexp = '{ST, ST, 8'h11, 8'h22};
`else
        mexp = '{ST, ST, ST, ST};
`endif
        model_frame(tx, ex, we);
        wlog.delete();
        start_frame();
        foreach (tx[k]) begin send_byte(tx[k], b); rx.push_back(b); end
        tests++; if (frame_active !== 1'b1) begin fails++; $display("FAIL write_ai frame_active got %b exp 1", frame_active); end
        end_frame();
        tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL write_ai frame_active after ss got %b exp 0", frame_active); end
        tests++; if (wlog.size() != 3) begin fails++; $display("FAIL write_ai write count got %0d exp 3", wlog.size()); end
        else foreach (wexp[i]) begin
            tests++; if (wlog[i] !== wexp[i]) begin fails++; $display("FAIL write_ai write[%0d] got %h exp %h", i, wlog[i], wexp[i]); end
        end
        foreach (mexp[i]) begin
            tests++; if (rx[i] !== mexp[i]) begin fails++; $display("FAIL write_ai miso[%0d] got %h exp %h", i, rx[i], mexp[i]); end
        end
    endtask
    task automatic test_read_ai();
        bq_t tx, rx, ex, mexp;
        wq_t we;
        poke(6'h3E, 8'h7A); poke(6'h3F, 8'h7B); poke(6'h00, 8'h7C);
        tx = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};
        mexp = '{ST, ST, 8'h7A, 8'h7B, 8'h7C};
        model_frame(tx, ex, we);
        wlog.delete();
        run_frame(tx, rx);
        foreach (mexp[i]) begin
            tests++; if (rx[i] !== mexp[i]) begin fails++; $display("FAIL read_ai miso[%0d] got %h exp %h", i, rx[i], mexp[i]); end
        end
        tests++; if (wlog.size() != 0) begin fails++; $display("FAIL read_ai write count got %0d exp 0", wlog.size()); end
    endtask
    task automatic test_fixed_write();
        bq_t tx, rx, ex;
        wq_t we;
        tx = '{8'h85, 8'h01, 8'h02};
        model_frame(tx, ex, we);
        wlog.delete();
        run_frame(tx, rx);
        tests++; if (wlog.size() != 2) begin fails++; $display("FAIL fixed write count got %0d exp 2", wlog.size()); end
        else begin
            tests++; if (wlog[0] !== {6'd5, 8'h01}) begin fails++; $display("FAIL fixed write[0] got %h exp %h", wlog[0], {6'd5, 8'h01}); end
            tests++; if (wlog[1] !== {6'd5, 8'h02}) begin fails++; $display("FAIL fixed write[1] got %h exp %h", wlog[1], {6'd5, 8'h02}); end
        end
        tests++; if (reg_addr !== 6'd5) begin fails++; $display("FAIL fixed reg_addr got %h exp 05", reg_addr); end
    endtask
    task automatic test_echo();
        bq_t tx, rx, ex, mexp;
        wq_t we;
        tx = '{8'hC0, 8'h5A, 8'h3C};
`ifdef SPI_REG_BRIDGE_ECHO_EN
        mexp = '{ST, ST, 8'h5A};
`else
        mexp = '{ST, ST, ST};
`endif
        model_frame(tx, ex, we);
        run_frame(tx, rx);
        foreach (mexp[i]) begin
            tests++; if (rx[i] !== mexp[i]) begin fails++; $display("FAIL echo miso[%0d] got %h exp %h", i, rx[i], mexp[i]); end
        end
    endtask
    task automatic test_abort();
        bq_t tx, rx, ex;
        wq_t we;
        logic [7:0] b;
        wlog.delete();
        start_frame();
        send_byte(8'hC0, b);
        tick(8);
        ss = 1;
        tick(3);
        tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL abort frame_active got %b exp 0", frame_active); end
        tests++; if (spi_din !== ST) begin fails++; $display("FAIL abort spi_din got %h exp %h", spi_din, ST); end
        tests++; if (dut.state !== spi_reg_pkg::HDR) begin fails++; $display("FAIL abort state got %0d exp HDR", dut.state); end
        tick(3);
        tests++; if (wlog.size() != 0) begin fails++; $display("FAIL abort write count got %0d exp 0", wlog.size()); end
        tx = '{8'h8A, 8'h77};
        model_frame(tx, ex, we);
        run_frame(tx, rx);
        tests++; if (wlog.size() != 1 || wlog[0] !== {6'd10, 8'h77}) begin fails++; $display("FAIL abort next frame writes got %0d entries first %h exp 1 entry %h", wlog.size(), wlog.size() > 0 ? wlog[0] : 14'h0, {6'd10, 8'h77}); end
    endtask
    task automatic test_done_with_abort();
        logic [7:0] b;
        wlog.delete();
        start_frame();
        send_byte(8'hC8, b);
        send_byte(8'hAB, b);
        tick(12);
        ss = 1;
        tick(2);
        spi_dout = 8'hCD; spi_done = 1;
        tick();
        spi_done = 0;
        tick(3);
        ref_mem[8] = 8'hAB; ref_mem[9] = 8'hCD;
        tests++; if (wlog.size() != 2 || wlog[1] !== {6'd9, 8'hCD}) begin fails++; $display("FAIL done_abort writes got %0d entries last %h exp 2 entries last %h", wlog.size(), wlog.size() > 0 ? wlog[wlog.size()-1] : 14'h0, {6'd9, 8'hCD}); end
        tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL done_abort frame_active got %b exp 0", frame_active); end
    endtask
    task automatic test_reset_midread();
        bq_t tx, rx, ex;
        wq_t we;
        logic [7:0] b;
        start_frame();
        send_byte(8'h41, b);
        tick(14);
        spi_dout = 8'h00; spi_done = 1;
        tick();
        spi_done = 0;
        tests++; if (reg_re !== 1'b1) begin fails++; $display("FAIL rst_midread reg_re before reset got %b exp 1", reg_re); end
        rst = 0;
        #1;
        tests++; if ({spi_din, reg_addr, reg_wdata} !== {ST, 6'd0, 8'd0}) begin fails++; $display("FAIL rst_midread din/addr/wdata got %h %h %h exp %h 00 00", spi_din, reg_addr, reg_wdata, ST); end
        tests++; if ({reg_we, reg_re, frame_active} !== 3'b000) begin fails++; $display("FAIL rst_midread strobes got %b exp 000", {reg_we, reg_re, frame_active}); end
        ss = 1;
        tick(3);
        rst = 1;
        tick(3);
        tx = '{8'h5F, 8'h00, 8'h00, 8'h00};
        model_frame(tx, ex, we);
        run_frame(tx, rx);
        foreach (ex[i]) begin
            tests++; if (rx[i] !== ex[i]) begin fails++; $display("FAIL rst_midread next miso[%0d] got %h exp %h", i, rx[i], ex[i]); end
        end
    endtask
    task automatic test_random();
        bq_t tx, rx, ex;
        wq_t we;
        for (int f = 0; f < 24; f++) begin
            tx = {};
            tx.push_back(8'($urandom));
            repeat ($urandom_range(1, 6)) tx.push_back(8'($urandom));
            model_frame(tx, ex, we);
            wlog.delete();
            run_frame(tx, rx);
            foreach (ex[i]) begin
                tests++; if (rx[i] !== ex[i]) begin fails++; $display("FAIL random f%0d hdr %h miso[%0d] got %h exp %h", f, tx[0], i, rx[i], ex[i]); end
            end
            tests++; if (wlog.size() != we.size()) begin fails++; $display("FAIL random f%0d hdr %h write count got %0d exp %0d", f, tx[0], wlog.size(), we.size()); end
            else foreach (we[i]) begin
                tests++; if (wlog[i] !== we[i]) begin fails++; $display("FAIL random f%0d write[%0d] got %h exp %h", f, i, wlog[i], we[i]); end
            end
        end
    endtask
    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        test_reset();
        test_write_ai();
        test_read_ai();
        test_fixed_write();
        test_echo();
        test_abort();
        test_done_with_abort();
        test_reset_midread();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
